// File: rtl/ravenoc_pkg.sv
// Shared NoC types: flit type encoding, injector FSM states, LFSR taps and step function.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ravenoc_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'b00,
        FLIT_BODY = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_TAIL
    } inj_state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois step: the bit shifted out folds the taps back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

endpackage

// File: rtl/noc_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and enable-gated advance.
// Latency: new state visible the cycle after load_i/adv_i.
// Backpressure: holds state whenever adv_i is low.
// Ports: clk, arst (async, active-high); load_i/seed_i load a seed (0 becomes 1);
//        adv_i steps once per cycle; state_o is the current register value.
module noc_lfsr32
    import ravenoc_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            // All-zero is the lock-up state of an XOR LFSR.
            state_d = (seed_i == 32'd0) ? 32'd1 : seed_i;
        end else if (adv_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= 32'd1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/noc_flit_injector.sv
// Packet traffic source: per start request emits HEAD, (BODY)*, TAIL flits with LFSR payload on one VC.
// Latency: first flit valid 1 cycle after start_i; done_o 1 cycle after the final handshake.
// Backpressure: flit held stable while ready_i[vc_id_o] is low; LFSR frozen; start_i ignored while busy.
// Ports: clk, arst (async, active-high); start_i + x_dest_i/y_dest_i/vc_id_i/pkt_size_i/seed_i request a
//        packet; flit_data_o/valid_o/vc_id_o with per-VC ready_i; busy_o, done_o pulse, pkt_cnt_o counter.
module noc_flit_injector
    import ravenoc_pkg::*;
#(
    parameter int FLIT_WIDTH = 34,
    parameter int NUM_VC     = 2,
    parameter int X_WIDTH    = 2,
    parameter int Y_WIDTH    = 2,
    parameter int PKT_WIDTH  = 8,
    localparam int VCW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start_i,
    input  logic [X_WIDTH-1:0]    x_dest_i,
    input  logic [Y_WIDTH-1:0]    y_dest_i,
    input  logic [VCW-1:0]        vc_id_i,
    input  logic [PKT_WIDTH-1:0]  pkt_size_i,
    input  logic [31:0]           seed_i,
    output logic [FLIT_WIDTH-1:0] flit_data_o,
    output logic                  valid_o,
    output logic [VCW-1:0]        vc_id_o,
    input  logic [NUM_VC-1:0]     ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           pkt_cnt_o
);

    localparam int PW = FLIT_WIDTH - 2;                         // payload bits below the type field
    localparam int HR = PW - X_WIDTH - Y_WIDTH - PKT_WIDTH;     // LFSR bits left in a head flit

    inj_state_e           state_q, state_d;
    logic [X_WIDTH-1:0]   x_q, x_d;
    logic [Y_WIDTH-1:0]   y_q, y_d;
    logic [VCW-1:0]       vc_q, vc_d;
    logic [PKT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;

    logic [31:0]          lfsr_state;
    logic                 lfsr_load;
    logic                 hs;
    logic [PW-1:0]        payload;
    logic [VCW-1:0]       vc_clamped;

    noc_lfsr32 u_lfsr (
        .clk     (clk),
        .arst    (arst),
        .load_i  (lfsr_load),
        .seed_i  (seed_i),
        .adv_i   (hs),
        .state_o (lfsr_state)
    );

    generate
        if (PW > 32) begin : g_pl_ext
            assign payload = {{(PW-32){1'b0}}, lfsr_state};
        end else begin : g_pl_trunc
            assign payload = lfsr_state[PW-1:0];
        end
    endgenerate

    // Only reachable when NUM_VC is not a power of two.
    assign vc_clamped = ({{(32-VCW){1'b0}}, vc_id_i} >= 32'(NUM_VC)) ? VCW'(NUM_VC - 1) : vc_id_i;

    assign valid_o = (state_q != ST_IDLE);
    assign busy_o  = valid_o;
    assign vc_id_o = valid_o ? vc_q : '0;
    assign hs      = valid_o & ready_i[vc_q];

    // cnt_q holds pkt_size while in HEAD (it doubles as the head's size field),
    // then the number of flits still to send, including the current one.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        vc_d        = vc_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        lfsr_load   = 1'b0;
        flit_data_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    x_d       = x_dest_i;
                    y_d       = y_dest_i;
                    vc_d      = vc_clamped;
                    cnt_d     = pkt_size_i;
                    lfsr_load = 1'b1;
                    state_d   = ST_HEAD;
                end
            end
            ST_HEAD: begin
                flit_data_o = {FLIT_HEAD, x_q, y_q, cnt_q, payload[HR-1:0]};
                if (hs) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (cnt_q == PKT_WIDTH'(1)) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                flit_data_o = {FLIT_BODY, payload};
                if (hs) begin
                    cnt_d = cnt_q - PKT_WIDTH'(1);
                    if (cnt_q == PKT_WIDTH'(2)) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                flit_data_o = {FLIT_TAIL, payload};
                if (hs) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pkt_cnt_d = pkt_cnt_q + {15'd0, done_d};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            vc_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vc_q      <= vc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign done_o    = done_q;
    assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_noc_flit_injector.sv
// Directed bench for noc_flit_injector: expected flits queued at start, popped on each handshake.
// Latency: samples outputs on the falling edge, drives inputs 1 time unit after the rising edge.
// Backpressure: drives per-VC ready patterns to exercise stalls.
module tb_noc_flit_injector;

    typedef struct packed {
        logic [33:0] dat;
        logic        vc;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst;
    logic        start_i;
    logic [1:0]  x_dest_i;
    logic [1:0]  y_dest_i;
    logic        vc_id_i;
    logic [7:0]  pkt_size_i;
    logic [31:0] seed_i;
    logic [33:0] flit_data_o;
    logic        valid_o;
    logic        vc_id_o;
    logic [1:0]  ready_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] pkt_cnt_o;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    noc_flit_injector dut (
        .clk         (clk),
        .arst        (arst),
        .start_i     (start_i),
        .x_dest_i    (x_dest_i),
        .y_dest_i    (y_dest_i),
        .vc_id_i     (vc_id_i),
        .pkt_size_i  (pkt_size_i),
        .seed_i      (seed_i),
        .flit_data_o (flit_data_o),
        .valid_o     (valid_o),
        .vc_id_o     (vc_id_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] t;
        t = {1'b0, s[31:1]};
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic push_pkt(input logic [1:0] x, input logic [1:0] y, input logic vc,
                            input logic [7:0] size, input logic [31:0] seed);
        logic [31:0] s;
        exp_t        e;
        s     = (seed == 32'd0) ? 32'd1 : seed;
        e.vc  = vc;
        e.dat = {2'b00, x, y, size, s[19:0]};
        sb.push_back(e);
        for (int i = 1; i <= int'(size); i++) begin
            s     = ref_step(s);
            e.dat = {((i == int'(size)) ? 2'b10 : 2'b01), s};
            sb.push_back(e);
        end
    endtask

    task automatic start_pkt(input logic [1:0] x, input logic [1:0] y, input logic vc,
                             input logic [7:0] size, input logic [31:0] seed);
        x_dest_i   = x;
        y_dest_i   = y;
        vc_id_i    = vc;
        pkt_size_i = size;
        seed_i     = seed;
        push_pkt(x, y, vc, size, seed);
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
    endtask

    // Counts falling edges until done_o is seen; an expired budget is a failed check.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done_o) break;
        end
        if (!done_o) chk("done_timeout", {63'd0, done_o}, 64'd1);
    endtask

    // Handshake monitor: scoreboard compare, plus hold-stable checks across stalls.
    logic        prev_stall = 1'b0;
    logic [33:0] prev_dat;
    logic        prev_vc;
    always @(negedge clk) begin
        exp_t e;
        if (prev_stall && !arst) begin
            chk("stall_valid_held", {63'd0, valid_o}, 64'd1);
            chk("stall_dat_stable", {30'd0, flit_data_o}, {30'd0, prev_dat});
            chk("stall_vc_stable", {63'd0, vc_id_o}, {63'd0, prev_vc});
        end
        if (valid_o && ready_i[vc_id_o]) begin
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_flit: observed=%0h expected=none", flit_data_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("flit_dat", {30'd0, flit_data_o}, {30'd0, e.dat});
                chk("flit_vc", {63'd0, vc_id_o}, {63'd0, e.vc});
            end
        end
        prev_stall = valid_o && !ready_i[vc_id_o];
        prev_dat   = flit_data_o;
        prev_vc    = vc_id_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        arst       = 1'b1;
        start_i    = 1'b0;
        x_dest_i   = 2'd0;
        y_dest_i   = 2'd0;
        vc_id_i    = 1'b0;
        pkt_size_i = 8'd0;
        seed_i     = 32'd0;
        ready_i    = 2'b11;

        // Reset state
        repeat (10) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_cnt", {48'd0, pkt_cnt_o}, 64'd0);
        chk("rst_dat", {30'd0, flit_data_o}, 64'd0);
        arst = 1'b0;
        @(negedge clk);

        // 1: head-only packet, y=3
        start_pkt(2'd0, 2'd3, 1'b0, 8'd0, 32'hA5A5_1234);
        chk("t1_valid_lat", {63'd0, valid_o}, 64'd1);
        chk("t1_busy", {63'd0, busy_o}, 64'd1);
        wait_done(10, n);
        chk("t1_done_lat", n, 64'd2);
        chk("t1_cnt", {48'd0, pkt_cnt_o}, 64'd1);
        chk("t1_valid_off", {63'd0, valid_o}, 64'd0);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", {63'd0, done_o}, 64'd0);

        // 2: size=4 on VC1, full ready -> 5 consecutive flits
        start_pkt(2'd1, 2'd2, 1'b1, 8'd4, 32'h0000_0001);
        chk("t2_vc", {63'd0, vc_id_o}, 64'd1);
        wait_done(20, n);
        chk("t2_done_lat", n, 64'd6);
        chk("t2_cnt", {48'd0, pkt_cnt_o}, 64'd2);

        // 3: size=3 on VC1 with ready[1] = 1,0,0,1,1 and ready[0] held high; seed 0 -> 1
        start_pkt(2'd3, 2'd1, 1'b1, 8'd3, 32'd0);
        ready_i = 2'b11;
        @(posedge clk); #1;
        ready_i = 2'b01;
        @(posedge clk); #1;
        chk("t3_stall_busy", {63'd0, busy_o}, 64'd1);
        @(posedge clk); #1;
        ready_i = 2'b11;
        wait_done(20, n);
        chk("t3_done_lat", n, 64'd4);
        chk("t3_cnt", {48'd0, pkt_cnt_o}, 64'd3);

        // 4: start_i held through busy period and the final-handshake cycle
        start_pkt(2'd2, 2'd2, 1'b0, 8'd2, 32'hDEAD_BEEF);
        x_dest_i   = 2'd1;
        pkt_size_i = 8'd7;
        vc_id_i    = 1'b1;
        start_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("t4_done", {63'd0, done_o}, 64'd1);
        chk("t4_cnt", {48'd0, pkt_cnt_o}, 64'd4);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_idle_valid", {63'd0, valid_o}, 64'd0);
        chk("t4_idle_busy", {63'd0, busy_o}, 64'd0);
        chk("t4_cnt_hold", {48'd0, pkt_cnt_o}, 64'd4);

        // 5: async reset during the 2nd BODY of a size=5 packet
        start_pkt(2'd1, 2'd1, 1'b0, 8'd5, 32'h1357_9BDF);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_pre_type", {62'd0, flit_data_o[33:32]}, 64'd1);
        arst = 1'b1;
        sb.delete();
        #1;
        chk("t5_rst_valid", {63'd0, valid_o}, 64'd0);
        chk("t5_rst_busy", {63'd0, busy_o}, 64'd0);
        chk("t5_rst_dat", {30'd0, flit_data_o}, 64'd0);
        chk("t5_rst_vc", {63'd0, vc_id_o}, 64'd0);
        chk("t5_rst_cnt", {48'd0, pkt_cnt_o}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_post_valid", {63'd0, valid_o}, 64'd0);
        end
        start_pkt(2'd3, 2'd3, 1'b1, 8'd1, 32'h0BAD_F00D);
        wait_done(10, n);
        chk("t5_done_lat", n, 64'd3);
        chk("t5_cnt", {48'd0, pkt_cnt_o}, 64'd1);

        // 6: counter wrap from 16'hFFFF
        @(negedge clk);
        force dut.pkt_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_cnt_q;
        #1;
        chk("t6_preload", {48'd0, pkt_cnt_o}, 64'hFFFF);
        start_pkt(2'd0, 2'd1, 1'b0, 8'd0, 32'h0000_00FF);
        wait_done(10, n);
        chk("t6_done", {63'd0, done_o}, 64'd1);
        chk("t6_wrap", {48'd0, pkt_cnt_o}, 64'd0);
        start_pkt(2'd2, 2'd0, 1'b1, 8'd0, 32'h8000_0000);
        wait_done(10, n);
        chk("t6_after_wrap", {48'd0, pkt_cnt_o}, 64'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
